// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, entity codes, palette.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  localparam logic [1:0] ENT_EMPTY = 2'b00;
  localparam logic [1:0] ENT_FOOD  = 2'b01;
  localparam logic [1:0] ENT_SNAKE = 2'b10;
  localparam logic [1:0] ENT_WALL  = 2'b11;

  localparam logic [11:0] COL_EMPTY = 12'h000;
  localparam logic [11:0] COL_FOOD  = 12'hF00;
  localparam logic [11:0] COL_SNAKE = 12'h0F0;
  localparam logic [11:0] COL_WALL  = 12'hFFF;

  // Entity code to {R,G,B} nibble colour.
  function automatic logic [11:0] ent_colour(input logic [1:0] code);
    case (code)
      ENT_FOOD:  return COL_FOOD;
      ENT_SNAKE: return COL_SNAKE;
      ENT_WALL:  return COL_WALL;
      default:   return COL_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raw raster counters plus undelayed active/sync flags and end-of-frame pulse.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output logic       active_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       frame_end_o
);

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HSS = H_ACTIVE + H_FP;
  localparam int HSE = HSS + H_SYNC - 1;
  localparam int VSS = V_ACTIVE + V_FP;
  localparam int VSE = VSS + V_SYNC - 1;

  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic       h_wrap, v_wrap;

  // Next raster position: h wraps every line, v steps only on the h wrap.
  always_comb begin
    h_wrap  = (h_cnt_q == 10'(HT - 1));
    v_wrap  = (v_cnt_q == 10'(VT - 1));
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
  end

  // Counter registers; reset restarts the raster at (0,0).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign active_o    = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
  assign hsync_o     = !((h_cnt_q >= 10'(HSS)) && (h_cnt_q <= 10'(HSE)));
  assign vsync_o     = !((v_cnt_q >= 10'(VSS)) && (v_cnt_q <= 10'(VSE)));
  assign frame_end_o = h_wrap && v_wrap;

endmodule

// File: rtl/vga_entity_renderer.sv
// VGA raster driver: emits coordinates, maps returned entity codes to RGB,
// blinks inverted colours on game over, and delay-matches sync/de to RGB.
module vga_entity_renderer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int ENT_LAT    = 1,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [9:0]  VGA_X,
  output logic [9:0]  VGA_Y,
  input  logic [0:1]  cur_ent_code,
  input  logic        game_over,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [11:0] vga_rgb,
  output logic        frame_end
);

  localparam int STAGES = ENT_LAT + 1;
  localparam int BW     = BLINK_LOG2 + 1;

  logic act_raw, hs_raw, vs_raw, fe_raw;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i       (sys_clk),
    .rst_ni      (sys_rst),
    .h_cnt_o     (VGA_X),
    .v_cnt_o     (VGA_Y),
    .active_o    (act_raw),
    .hsync_o     (hs_raw),
    .vsync_o     (vs_raw),
    .frame_end_o (fe_raw)
  );

  // Index 0 is the raw flag; index k is the flag k cycles old.
  logic [STAGES-1:0] vld_q, hs_q, vs_q;
  logic [STAGES:0]   vld_pipe, hs_pipe, vs_pipe;
  logic [BW-1:0]     blink_q, blink_d;
  logic              go_q;
  logic [11:0]       rgb_q, rgb_d;

  assign vld_pipe = {vld_q, act_raw};
  assign hs_pipe  = {hs_q, hs_raw};
  assign vs_pipe  = {vs_q, vs_raw};

  // Blink counter only advances on frames that started with game_over
  // already high, so a rising edge coinciding with frame_end starts at 0.
  always_comb begin
    blink_d = blink_q;
    if (!game_over)            blink_d = '0;
    else if (fe_raw && go_q)   blink_d = blink_q + BW'(1);
  end

  // Colour for the coordinate issued ENT_LAT cycles ago; blanked outside active.
  always_comb begin
    rgb_d = ent_colour(cur_ent_code);
    if (game_over && blink_q[BW-1]) rgb_d = ~rgb_d;
    if (!vld_pipe[ENT_LAT])         rgb_d = '0;
  end

  // Delay line, blink state and output colour register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      vld_q   <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
      blink_q <= '0;
      go_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      vld_q   <= vld_pipe[STAGES-1:0];
      hs_q    <= hs_pipe[STAGES-1:0];
      vs_q    <= vs_pipe[STAGES-1:0];
      blink_q <= blink_d;
      go_q    <= game_over;
      rgb_q   <= rgb_d;
    end
  end

  assign vga_de    = vld_pipe[STAGES];
  assign vga_hsync = hs_pipe[STAGES];
  assign vga_vsync = vs_pipe[STAGES];
  assign vga_rgb   = rgb_q;
  assign frame_end = fe_raw;

endmodule

// File: tb/tb_vga_entity_renderer.sv
// Bench for vga_entity_renderer on a shrunken raster (24x13 clocks per frame).
module tb_vga_entity_renderer;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int LAT = 1, BL = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  vx, vy;
  logic [0:1]  code;
  logic        go;
  logic        hs, vs, de, fe;
  logic [11:0] rgb;

  int total = 0, bad = 0;
  int n = 0;            // cycles since reset release = raster position
  int pat = 0;          // entity pattern returned by the fake game logic
  bit go_ph = 1'b0;     // game_over level assumed by the model
  int mask_until = 0;   // rgb not checked while n < mask_until
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  vga_entity_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .ENT_LAT(LAT), .BLINK_LOG2(BL)
  ) dut (
    .sys_clk(clk), .sys_rst(rst_n), .VGA_X(vx), .VGA_Y(vy),
    .cur_ent_code(code), .game_over(go), .vga_hsync(hs), .vga_vsync(vs),
    .vga_de(de), .vga_rgb(rgb), .frame_end(fe)
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, n);
    end
  endtask

  function automatic logic [1:0] ent_fn(input int p, input int x, input int y);
    case (p)
      0:       return (x == 5 && y == 3) ? 2'b01 :
                      (x >= HA || y >= VA) ? 2'b11 : 2'b00;
      1:       return 2'b10;
      default: return 2'((x + y) % 4);
    endcase
  endfunction

  function automatic logic [11:0] pal(input logic [1:0] c, input bit inv);
    logic [11:0] r;
    case (c)
      2'b01:   r = 12'hF00;
      2'b10:   r = 12'h0F0;
      2'b11:   r = 12'hFFF;
      default: r = 12'h000;
    endcase
    return inv ? ~r : r;
  endfunction

  // Model clock: position in the raster since reset.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else        n <= n + 1;

  // Fake game logic: answer for the coordinate issued LAT cycles earlier.
  always @(negedge clk) begin
    int m;
    m = n - LAT;
    if (m < 0) m = 0;
    code = ent_fn(pat, m % HT, (m / HT) % VT);
  end

  // Per-cycle comparison against the raster model.
  always @(negedge clk) if (run_chk) begin
    int h, v, d, dh, dv;
    bit act, inv;
    logic [11:0] er;
    if (!rst_n) begin
      chk("rst_x", vx, 0);   chk("rst_y", vy, 0);
      chk("rst_hs", hs, 1);  chk("rst_vs", vs, 1);
      chk("rst_de", de, 0);  chk("rst_rgb", rgb, 0);
      chk("rst_fe", fe, 0);
    end else begin
      h = n % HT;
      v = (n / HT) % VT;
      chk("vga_x", vx, h);
      chk("vga_y", vy, v);
      chk("frame_end", fe, (h == HT - 1 && v == VT - 1) ? 1 : 0);
      d = n - (LAT + 1);
      if (d < 0) begin
        chk("hs_early", hs, 1); chk("vs_early", vs, 1);
        chk("de_early", de, 0); chk("rgb_early", rgb, 0);
      end else begin
        dh = d % HT;
        dv = (d / HT) % VT;
        act = (dh < HA) && (dv < VA);
        inv = go_ph && (((d / FRAME) >> BL) & 1) == 1;
        er  = act ? pal(ent_fn(pat, dh, dv), inv) : 12'h000;
        chk("hsync", hs, (dh >= HA + HFP && dh < HA + HFP + HS) ? 0 : 1);
        chk("vsync", vs, (dv >= VA + VFP && dv < VA + VFP + VS) ? 0 : 1);
        chk("de", de, act ? 1 : 0);
        if (n >= mask_until) chk("rgb", rgb, er);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic goto(input int t);
    int guard;
    guard = 0;
    while (n < t && guard < 20000) begin step(); guard++; end
  endtask

  task automatic find_xy(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (vx == 10'(x) && vy == 10'(y)) begin ok = 1'b1; break; end
      step();
    end
  endtask

  initial begin
    int hl, vl, dl, fec, fen, cnt;
    bit ok;
    rst_n = 1'b0; go = 1'b0; code = 2'b00;
    #1 run_chk = 1'b1;

    // Reset held for 10 cycles.
    repeat (10) step();
    chk("hold_hs", hs, 1);  chk("hold_vs", vs, 1);
    chk("hold_rgb", rgb, 0); chk("hold_de", de, 0);
    chk("hold_x", vx, 0);   chk("hold_y", vy, 0);
    rst_n = 1'b1;
    chk("step0", vx, 0);
    for (int i = 1; i <= 3; i++) begin step(); chk("step", vx, i); end

    // One full frame window: sync widths, active area, frame_end position.
    hl = 0; vl = 0; dl = 0; fec = 0; fen = -1;
    repeat (FRAME) begin
      step();
      if (!hs) hl++;
      if (!vs) vl++;
      if (de)  dl++;
      if (fe) begin fec++; fen = n; end
    end
    chk("hs_low_per_frame", hl, 52);
    chk("vs_low_cycles", vl, 48);
    chk("de_cycles", dl, 128);
    chk("fe_count", fec, 1);
    chk("fe_pos", fen, 311);

    // Single food pixel at (5,3): two-cycle latency, neighbours dark.
    find_xy(5, 3, ok);
    chk("find_5_3", ok, 1);
    step(); chk("px_4_3", rgb, 12'h000);
    step(); chk("px_5_3", rgb, 12'hF00);
    step(); chk("px_6_3", rgb, 12'h000);
    // Wall code in blanking must not reach the pins.
    find_xy(HA, 2, ok);
    chk("find_blank", ok, 1);
    step(); step(); chk("blank_wall", rgb, 12'h000);

    // Blink: snake everywhere with game_over held from reset.
    rst_n = 1'b0; pat = 1; go = 1'b1; go_ph = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    goto(2);              chk("blink_f0", rgb, 12'h0F0);
    goto(4 * FRAME + 2);  chk("blink_f4", rgb, 12'hF0F);
    goto(8 * FRAME + 2);  chk("blink_f8", rgb, 12'h0F0);
    goto(12 * FRAME + 2); chk("blink_f12", rgb, 12'hF0F);
    go = 1'b0; go_ph = 1'b0; mask_until = n + 3;
    goto(mask_until);     chk("blink_off", rgb, 12'h0F0);
    repeat (40) step();

    // Reset mid-frame inside the vsync pulse.
    rst_n = 1'b0; pat = 2;
    repeat (3) step();
    rst_n = 1'b1;
    find_xy(20, 9, ok);
    chk("find_20_9", ok, 1);
    chk("pre_rst_vs", vs, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_x", vx, 0);   chk("mid_y", vy, 0);
    chk("mid_hs", hs, 1);  chk("mid_vs", vs, 1);
    chk("mid_de", de, 0);  chk("mid_rgb", rgb, 0);
    chk("mid_fe", fe, 0);
    repeat (3) step();
    rst_n = 1'b1;
    cnt = 0;
    while (!fe && cnt < 2 * FRAME) begin step(); cnt++; end
    chk("fe_after_rst", cnt, FRAME - 1);
    repeat (30) step();

    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
